// File: rtl/xunit_msched_if.sv
// Bundles the start/configuration inputs and the schedule-word outputs of xunit_msched.
// No latency of its own; it only carries the signals.
// No backpressure: the scheduler streams one word per cycle and never stalls.
interface xunit_msched_if #(
    parameter int DATA_W = 32
);
    logic              run;
    logic [DATA_W-1:0] in0;
    logic [7:0]        delay0;
    logic [DATA_W-1:0] out0;
    logic [DATA_W-1:0] out1;
    logic              out_valid;
    logic              done;

    // Driver side: issues run, supplies message words and the start delay.
    modport master (
        output run,
        output in0,
        output delay0,
        input  out0,
        input  out1,
        input  out_valid,
        input  done
    );

    // Scheduler side.
    modport slave (
        input  run,
        input  in0,
        input  delay0,
        output out0,
        output out1,
        output out_valid,
        output done
    );
endinterface

// File: rtl/xunit_msched.sv
// SHA-256 message scheduler: loads 16 words, expands to 64 W_t; K_t on out1 when XUNIT_MSCHED_KCONST_EN is defined.
// Latency in0 -> out0 is one cycle; first in0 sample happens delay0+2 edges after the run edge.
// No backpressure: one word per cycle, no stalls; run restarts the block from any state.
module xunit_msched #(
    parameter int DATA_W = 32,
    parameter int ROUNDS = 64
) (
    input  logic           clk,
    input  logic           rst,
    xunit_msched_if.slave  bus
);

    localparam int T_W = $clog2(ROUNDS);
    localparam logic [T_W-1:0] T_LOAD_LAST  = T_W'(15);
    localparam logic [T_W-1:0] T_ROUND_LAST = T_W'(ROUNDS - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DELAY  = 2'd1,
        S_LOAD   = 2'd2,
        S_EXPAND = 2'd3
    } state_t;

    // Small sigma functions of the SHA-256 schedule.
    function automatic logic [DATA_W-1:0] sig0(input logic [DATA_W-1:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
    endfunction

    function automatic logic [DATA_W-1:0] sig1(input logic [DATA_W-1:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
    endfunction

    state_t            state_q, state_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [T_W-1:0]    t_q, t_d;
    logic [DATA_W-1:0] win_q [16];
    logic [DATA_W-1:0] win_d [16];
    logic [DATA_W-1:0] out0_q, out0_d;
    logic [DATA_W-1:0] out1_q, out1_d;
    logic              vld_q, vld_d;

    logic [DATA_W-1:0] w_exp;
    logic [DATA_W-1:0] w_new;
    logic [DATA_W-1:0] k_cur;

`ifdef XUNIT_MSCHED_KCONST_EN
    localparam logic [31:0] K_TAB [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };
    // Round constant for the word produced this cycle, indexed by the round counter.
    assign k_cur = K_TAB[t_q];
`else
    // Without the constant table out1 is a constant zero.
    assign k_cur = '0;
`endif

    // Expansion word from the 16-word window (w[15] is W_{t-1}, w[0] is W_{t-16}).
    assign w_exp = sig1(win_q[14]) + win_q[9] + sig0(win_q[1]) + win_q[0];
    assign w_new = (state_q == S_LOAD) ? bus.in0 : w_exp;

    // Next-state logic: run has priority in every state and restarts the block.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        t_d     = t_q;
        win_d   = win_q;
        out0_d  = out0_q;
        out1_d  = out1_q;
        vld_d   = 1'b0;

        if (bus.run) begin
            state_d = S_DELAY;
            cnt_d   = bus.delay0;
            t_d     = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    // Hold W_63/K_63 on the outputs until the next run.
                end
                S_DELAY: begin
                    if (cnt_q != 8'd0) begin
                        cnt_d = cnt_q - 8'd1;
                    end else begin
                        state_d = S_LOAD;
                    end
                end
                S_LOAD, S_EXPAND: begin
                    for (int i = 0; i < 15; i++) begin
                        win_d[i] = win_q[i+1];
                    end
                    win_d[15] = w_new;
                    out0_d    = w_new;
                    out1_d    = k_cur;
                    vld_d     = 1'b1;
                    t_d       = t_q + T_W'(1);
                    if (state_q == S_LOAD && t_q == T_LOAD_LAST) begin
                        state_d = S_EXPAND;
                    end
                    if (state_q == S_EXPAND && t_q == T_ROUND_LAST) begin
                        state_d = S_IDLE;
                        t_d     = '0;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // State and datapath registers; reset clears everything at once, even mid-block.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            t_q     <= '0;
            for (int i = 0; i < 16; i++) begin
                win_q[i] <= '0;
            end
            out0_q  <= '0;
            out1_q  <= '0;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            t_q     <= t_d;
            win_q   <= win_d;
            out0_q  <= out0_d;
            out1_q  <= out1_d;
            vld_q   <= vld_d;
        end
    end

    assign bus.out0      = out0_q;
    assign bus.out1      = out1_q;
    assign bus.out_valid = vld_q;
    assign bus.done      = (state_q == S_IDLE);

endmodule

// File: tb/tb_xunit_msched.sv
// Directed bench for xunit_msched: reset, abc block, all-ones wrap, start delay, restart, mid-block reset.
// Expected schedule words come from an independent SHA-256 schedule model in the bench.
// Inputs are driven between clock edges; outputs are sampled on the falling edge.
module tb_xunit_msched;

    logic clk;
    logic rst;

    xunit_msched_if #(.DATA_W(32)) bus ();

    xunit_msched #(.DATA_W(32), .ROUNDS(64)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [31:0] msg   [16];
    logic [31:0] exp_w [64];
    logic [31:0] obs_w [64];

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // Reference schedule: W_t = s1(W_{t-2}) + W_{t-7} + s0(W_{t-15}) + W_{t-16}.
    task automatic compute_exp();
        logic [31:0] s0, s1;
        for (int t = 0; t < 64; t++) begin
            if (t < 16) begin
                exp_w[t] = msg[t];
            end else begin
                s0 = rotr(exp_w[t-15], 7) ^ rotr(exp_w[t-15], 18) ^ (exp_w[t-15] >> 3);
                s1 = rotr(exp_w[t-2], 17) ^ rotr(exp_w[t-2], 19) ^ (exp_w[t-2] >> 10);
                exp_w[t] = s1 + exp_w[t-7] + s0 + exp_w[t-16];
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
        end
    endtask

    // Issues run with delay d, feeds msg during LOAD and checks every cycle.
    // abort_at < 0: run to completion plus two idle cycles; otherwise return once W_{abort_at-1} is seen.
    task automatic run_block(input logic [7:0] d, input int abort_at, input string tag);
        int nvld;
        int last;
        int k;
        nvld = 0;
        bus.run    = 1'b1;
        bus.delay0 = d;
        bus.in0    = 32'hDEADBEEF;
        @(posedge clk);
        #1;
        bus.run = 1'b0;
        @(negedge clk);
        chk1({tag, "_start_vld"}, bus.out_valid, 1'b0);
        chk1({tag, "_start_done"}, bus.done, 1'b0);
        last = (abort_at < 0) ? int'(d) + 67 : int'(d) + 1 + abort_at;
        for (int e = 1; e <= last; e++) begin
            k = e - int'(d) - 2;
            if (k >= 0 && k < 16) bus.in0 = msg[k];
            else                  bus.in0 = 32'hDEADBEEF ^ 32'(e);
            @(posedge clk);
            @(negedge clk);
            if (bus.out_valid) nvld++;
            chk1($sformatf("%s_vld_e%0d", tag, e), bus.out_valid, (k >= 0 && k < 64));
            chk1($sformatf("%s_done_e%0d", tag, e), bus.done, (k >= 63));
            if (k >= 0 && k < 64) begin
                obs_w[k] = bus.out0;
                chk($sformatf("%s_w%0d", tag, k), bus.out0, exp_w[k]);
            end else if (k > 63) begin
                chk($sformatf("%s_hold_e%0d", tag, e), bus.out0, exp_w[63]);
            end
`ifdef XUNIT_MSCHED_KCONST_EN
            if (k == 0)  chk($sformatf("%s_k0", tag), bus.out1, 32'h428A2F98);
            if (k >= 63) chk($sformatf("%s_k63_e%0d", tag, e), bus.out1, 32'hC67178F2);
`else
            chk($sformatf("%s_out1_e%0d", tag, e), bus.out1, 32'h0);
`endif
        end
        if (abort_at < 0) chk({tag, "_nvld"}, 32'(nvld), 32'd64);
        else              chk({tag, "_nvld"}, 32'(nvld), 32'(abort_at));
    endtask

    initial begin
        rst        = 1'b0;
        bus.run    = 1'b0;
        bus.in0    = 32'h0;
        bus.delay0 = 8'd0;
        #2;
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("rst_out0", bus.out0, 32'h0);
        chk("rst_out1", bus.out1, 32'h0);
        chk1("rst_vld", bus.out_valid, 1'b0);
        chk1("rst_done", bus.done, 1'b1);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk1("idle_done", bus.done, 1'b1);
        chk1("idle_vld", bus.out_valid, 1'b0);

        // "abc" padded block, no start delay.
        for (int i = 0; i < 16; i++) msg[i] = 32'h0;
        msg[0]  = 32'h61626380;
        msg[15] = 32'h00000018;
        compute_exp();
        run_block(8'd0, -1, "abc");
        chk("abc_w16_const", obs_w[16], 32'h61626380);
        chk("abc_w17_const", obs_w[17], 32'h000F0000);

        // All-ones block with a three-cycle start delay: exercises mod 2^32 wrap.
        for (int i = 0; i < 16; i++) msg[i] = 32'hFFFFFFFF;
        compute_exp();
        run_block(8'd3, -1, "ones");
        chk("ones_w16_const", obs_w[16], 32'h203FFFFC);

        // Restart at t=30, then the full block again from scratch.
        for (int i = 0; i < 16; i++) msg[i] = 32'(i + 1) * 32'h9E3779B9;
        compute_exp();
        run_block(8'd1, 30, "pre_restart");
        run_block(8'd2, -1, "restart");

        // Reset in the middle of EXPAND.
        for (int i = 0; i < 16; i++) msg[i] = 32'h0;
        msg[0]  = 32'h61626380;
        msg[15] = 32'h00000018;
        compute_exp();
        run_block(8'd0, 40, "pre_rst");
        rst = 1'b1;
        #1;
        chk("midrst_out0", bus.out0, 32'h0);
        chk("midrst_out1", bus.out1, 32'h0);
        chk1("midrst_vld", bus.out_valid, 1'b0);
        chk1("midrst_done", bus.done, 1'b1);
        @(negedge clk);
        chk1("midrst_vld2", bus.out_valid, 1'b0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk1("post_rst_done", bus.done, 1'b1);
        chk1("post_rst_vld", bus.out_valid, 1'b0);
        chk("post_rst_out0", bus.out0, 32'h0);
        run_block(8'd0, -1, "abc2");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/xunit_msched.md
XUNIT_MSCHED -- requirements
Module: xunit_msched

Interface
REQ-001 Parameter DATA_W, default 32, word width; only 32 is supported.
REQ-002 Parameter ROUNDS, default 64, number of schedule words per block.
REQ-003 clk  input  1  clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 run  input  1  single-cycle start pulse.
REQ-006 in0  input  32  message word M_t, big-endian, supplied while loading.
REQ-007 delay0  input  8  configuration; cycles to wait after run before the first in0 sample.
REQ-008 out0  output  32  registered schedule word W_t.
REQ-009 out1  output  32  registered round constant K_t (see Configuration).
REQ-010 out_valid  output  1  high in every cycle where out0/out1 carry a new W_t/K_t.
REQ-011 done  output  1  high when idle.

Function
REQ-012 States: IDLE, DELAY, LOAD, EXPAND; done SHALL equal (state==IDLE).
REQ-013 run sampled high in any state: cnt<=delay0, t<=0, state<=DELAY; an in-flight block is abandoned (restart).
REQ-014 DELAY: cnt!=0 -> cnt<=cnt-1; cnt==0 -> state<=LOAD. The first in0 sample occurs delay0+2 edges after the run edge.
REQ-015 LOAD (t=0..15): shift in0 into a 16-word window (w[15] newest, w[0] oldest); out0<=in0; t<=t+1; leave for EXPAND after t=15.
REQ-016 EXPAND (t=16..63): Wn = sigma1(w[14]) + w[9] + sigma0(w[1]) + w[0], mod 2^32, carries discarded; shift Wn into the window; out0<=Wn; t<=t+1.
REQ-017 sigma0(x) = ROTR7 ^ ROTR18 ^ SHR3; sigma1(x) = ROTR17 ^ ROTR19 ^ SHR10.
REQ-018 The t=63 edge SHALL set state<=IDLE.
REQ-019 out_valid SHALL be high for exactly 64 consecutive cycles per block, the first being the cycle after the first in0 sample.
REQ-020 Latency in0 -> out0 is 1 cycle; one word per cycle; no stalls.
REQ-021 After completion, out0/out1 hold W_63/K_63 and out_valid is 0 until the next run.
REQ-022 in0 is ignored outside LOAD; run while in IDLE with no prior block behaves identically to a restart.

Reset
REQ-023 rst high SHALL immediately force state=IDLE, cnt=0, t=0, window=0, out0=0, out1=0, out_valid=0, done=1, including mid-block.
REQ-024 After rst deasserts, the block SHALL remain in IDLE until run.

Configuration
REQ-025 Macro XUNIT_MSCHED_KCONST_EN defined: out1 SHALL present the SHA-256 K_t table (64 entries, indexed by t), registered and aligned with out0.
REQ-026 Macro XUNIT_MSCHED_KCONST_EN undefined: no K table is built; out1 SHALL be tied to 0; all other behaviour is unchanged.

Verification
REQ-027 Assert rst mid-EXPAND -> next sample shows out0=0, out_valid=0, done=1.
REQ-028 Apply run with delay0=0 and the "abc" block (0x61626380, fourteen 0x0, 0x00000018) -> W_16=0x61626380, W_17=0x000F0000.
REQ-029 Load sixteen words of 0xFFFFFFFF -> W_16=0x203FFFFC (wrap-around).
REQ-030 Apply run with delay0=3 -> first in0 sample 5 edges after the run edge; out_valid high for exactly 64 cycles; done rises on the edge after the 64th word.
REQ-031 Apply run again at t=30 -> out_valid drops, the window restarts, and the full 64-word sequence repeats correctly.
REQ-032 With KCONST_EN defined -> out1=0x428A2F98 with W_0 and 0xC67178F2 with W_63; without it, out1 stays 0.
